turn_controller: RTL
====================

TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter CELLS, default 9, number of board cells; legal range 2..15.
REQ-002 Parameter TURN_TICKS, default 800, per-turn time budget in ticks; legal range 1..999.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 tick  input  1  timer decrement enable, one pulse per 10 ms.
REQ-006 start  input  1  game running enable.
REQ-007 game_end  input  2  nonzero = game over.
REQ-008 key_valid  input  1  key held; level.
REQ-009 key_code  input  4  cell index of held key.
REQ-010 board  input  2*CELLS  cell i state at [2i+1:2i]; 00 empty, 01 O, 10 X.
REQ-011 location  output  4  cell of last accepted move; CELLS = none.
REQ-012 mark  output  2  mark of last accepted move; 10 X, 01 O, 00 none.
REQ-013 mark_vld  output  1  one-cycle strobe per accepted move.
REQ-014 whos_turn  output  1  1 = X to move, 0 = O to move.
REQ-015 time_sec / time_tenth  output  4 each  BCD remaining time: cnt/100 and (cnt/10)%10.
REQ-016 timeout  output  1  one-cycle strobe when the turn timer expires.
REQ-017 reject  output  1  one-cycle strobe for a press on an occupied or out-of-range cell.

Function
REQ-018 The block SHALL implement states IDLE, PLAY, DONE; IDLE->PLAY when start=1 and game_end=0; PLAY->IDLE when start=0; any state->DONE when game_end!=0; DONE->IDLE when game_end returns to 0.
REQ-019 A press SHALL be the rising edge of key_valid (key_valid=1, registered previous value=0); a held key SHALL yield exactly one press.
REQ-020 A press SHALL be evaluated only in PLAY with counter>0; presses in other conditions SHALL be ignored without any strobe.
REQ-021 A press with key_code<CELLS and an empty cell SHALL, on the next edge: set location=key_code, mark=(whos_turn?10:01), pulse mark_vld, toggle whos_turn, reload counter to TURN_TICKS.
REQ-022 A press with key_code>=CELLS or a non-empty cell SHALL pulse reject and leave location, mark, whos_turn and counter unchanged.
REQ-023 In PLAY the counter SHALL decrement by 1 on each cycle with tick=1 and counter>0; counter SHALL hold in IDLE and DONE.
REQ-024 An accepted press and tick in the same cycle: reload SHALL win; no decrement.
REQ-025 timeout SHALL pulse once, on the cycle after the counter transitions 1->0.
REQ-026 time_sec/time_tenth SHALL be registered from the counter with one cycle of latency.
REQ-027 mark and location SHALL hold between accepted moves.

Reset
REQ-028 With rst=0 at a clock edge: state=IDLE, location=CELLS, mark=00, whos_turn=0, counter=TURN_TICKS, time outputs = digits of TURN_TICKS, mark_vld=timeout=reject=0, key edge register=0.
REQ-029 Reset asserted mid-turn SHALL discard any pending press in the same cycle; a key held through reset release SHALL NOT count as a press.

Configuration
REQ-030 Macro TURN_TIMEOUT_SKIP_EN defined: on the cycle after timeout, whos_turn SHALL toggle and counter SHALL reload to TURN_TICKS; play continues.
REQ-031 Macro TURN_TIMEOUT_SKIP_EN undefined: after timeout the counter SHALL stay 0, whos_turn SHALL hold, and all presses SHALL be ignored until reset or an IDLE->PLAY re-entry, which reloads the counter.

Verification
REQ-032 Reset, start=1, press cell 4 on empty board -> location=4, mark=01, mark_vld one cycle, whos_turn=1, time 8/0.
REQ-033 Hold key 2 for 50 cycles on empty cell -> exactly one mark_vld; second press on cell 2 with board[5:4]=01 -> reject pulse, no state change.
REQ-034 key_code=12 with CELLS=9 -> reject pulse, location unchanged.
REQ-035 800 ticks with no press -> time counts 8/0 down to 0/0, one timeout pulse; with TURN_TIMEOUT_SKIP_EN whos_turn toggles and time reloads 8/0; without, time stays 0/0 and presses are ignored.
REQ-036 game_end=2'b01 mid-turn -> counter frozen, presses ignored; game_end=0 then start=1 -> PLAY resumes; rst=0 mid-turn -> all outputs at REQ-028 values next edge.

Source files
------------

// File: rtl/turn_controller.sv
// Turn sequencer for a two-player board game: key edge detection, move validation,
// per-turn countdown with BCD display and timeout. Optional macro: TURN_TIMEOUT_SKIP_EN.
module turn_controller #(
    parameter int CELLS      = 9,
    parameter int TURN_TICKS = 800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [1:0]           game_end,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic [2*CELLS-1:0]   board,
    output logic [3:0]           location,
    output logic [1:0]           mark,
    output logic                 mark_vld,
    output logic                 whos_turn,
    output logic [3:0]           time_sec,
    output logic [3:0]           time_tenth,
    output logic                 timeout,
    output logic                 reject
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] LOC_NONE = 4'(CELLS);
    localparam logic [9:0] RELOAD   = 10'(TURN_TICKS);
`ifdef TURN_TIMEOUT_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    logic [1:0] r_state;
    logic       r_key_prev;
    logic [9:0] r_cnt;
    logic [3:0] r_location;
    logic [1:0] r_mark;
    logic       r_mark_vld;
    logic       r_whos_turn;
    logic [3:0] r_time_sec;
    logic [3:0] r_time_tenth;
    logic       r_timeout;
    logic       r_reject;

    logic       w_press;
    logic       w_eval;
    logic       w_valid_cell;
    logic       w_accept;
    logic       w_refuse;
    logic       w_dec;
    logic       w_expire;
    logic [1:0] w_state_nxt;
    logic [9:0] w_cnt_nxt;
    logic       w_turn_nxt;

    function automatic logic [1:0] cell_of(input logic [2*CELLS-1:0] b, input logic [3:0] idx);
        logic [1:0] v;
        v = 2'b00;
        for (int i = 0; i < CELLS; i++) begin
            v = (idx == 4'(i)) ? b[2*i +: 2] : v;
        end
        return v;
    endfunction

    function automatic logic [3:0] digit_hundreds(input logic [9:0] c);
        logic [9:0] q;
        q = c / 10'd100;
        return q[3:0];
    endfunction

    function automatic logic [3:0] digit_tens(input logic [9:0] c);
        logic [9:0] q;
        q = (c / 10'd10) % 10'd10;
        return q[3:0];
    endfunction

    // Press qualification and move validation
    always_comb begin
        w_press      = key_valid & ~r_key_prev;
        w_eval       = w_press && (r_state == ST_PLAY) && (r_cnt != 10'd0);
        w_valid_cell = (key_code < LOC_NONE) && (cell_of(board, key_code) == 2'b00);
        w_accept     = w_eval && w_valid_cell;
        w_refuse     = w_eval && !w_valid_cell;
        w_dec        = (r_state == ST_PLAY) && tick && (r_cnt != 10'd0) && !w_accept;
        w_expire     = w_dec && (r_cnt == 10'd1);
    end

    // Game state sequencing; a nonzero game_end overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (game_end != 2'b00) begin
            w_state_nxt = ST_DONE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = start ? ST_PLAY : ST_IDLE;
                ST_PLAY: w_state_nxt = start ? ST_PLAY : ST_IDLE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Turn timer and turn ownership; an accepted move outranks a same-cycle tick
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_turn_nxt = r_whos_turn;
        if (w_accept) begin
            w_cnt_nxt  = RELOAD;
            w_turn_nxt = ~r_whos_turn;
        end else if (w_dec) begin
            w_cnt_nxt = r_cnt - 10'd1;
        end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_PLAY)) begin
            w_cnt_nxt = RELOAD;
        end else if (SKIP_EN && r_timeout && (r_state == ST_PLAY)) begin
            w_cnt_nxt  = RELOAD;
            w_turn_nxt = ~r_whos_turn;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State, strobes and display registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_key_prev   <= 1'b0;
            r_cnt        <= RELOAD;
            r_location   <= LOC_NONE;
            r_mark       <= 2'b00;
            r_mark_vld   <= 1'b0;
            r_whos_turn  <= 1'b0;
            r_time_sec   <= digit_hundreds(RELOAD);
            r_time_tenth <= digit_tens(RELOAD);
            r_timeout    <= 1'b0;
            r_reject     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_key_prev   <= key_valid;
            r_cnt        <= w_cnt_nxt;
            r_whos_turn  <= w_turn_nxt;
            r_mark_vld   <= w_accept;
            r_reject     <= w_refuse;
            r_timeout    <= w_expire;
            r_time_sec   <= digit_hundreds(r_cnt);
            r_time_tenth <= digit_tens(r_cnt);
            if (w_accept) begin
                r_location <= key_code;
                r_mark     <= r_whos_turn ? 2'b10 : 2'b01;
            end else begin
                r_location <= r_location;
                r_mark     <= r_mark;
            end
        end
    end

    assign location   = r_location;
    assign mark       = r_mark;
    assign mark_vld   = r_mark_vld;
    assign whos_turn  = r_whos_turn;
    assign time_sec   = r_time_sec;
    assign time_tenth = r_time_tenth;
    assign timeout    = r_timeout;
    assign reject     = r_reject;

endmodule
